// File: rtl/lc3_seq_pkg.sv
// Shared constants for the LC3 stage sequencer: state encoding, default memory
// stage map and the HALT trap vector decoded beside it.
package lc3_seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // Fetch in stage 0, load/store in stage 2
  localparam logic [3:0] DEFAULT_MEM_STAGE_MASK = 4'b0101;

  localparam logic [7:0] TRAP_HALT_VEC = 8'h25;

  localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/lc3_wait_timer.sv
// Counts memory wait cycles for the stage sequencer and flags when the
// tolerated number of wait cycles has been reached.
module lc3_wait_timer
  import lc3_seq_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == WAIT_CNT_W'(MAX_WAIT));

  // Start loads the first wait cycle; the count saturates at MAX_WAIT
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = WAIT_CNT_W'(1);
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lc3_stage_sequencer.sv
// Instruction stage sequencer for the LC3 datapath: steps STAGE through the
// instruction, stretches memory stages on REQ/READY, and supports run/step/halt.
module lc3_stage_sequencer
  import lc3_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned STAGE_W        = 2,
  parameter logic [15:0] MEM_STAGE_MASK = 16'(DEFAULT_MEM_STAGE_MASK),
  parameter int unsigned MAX_WAIT       = 15,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  RUN_i,
  input  logic                  STEP_MODE_i,
  input  logic                  STEP_REQ_i,
  input  logic                  HALT_REQ_i,
  input  logic                  MEM_READY_i,
  output logic                  MEM_REQ_o,
  output logic [STAGE_W-1:0]    STAGE_o,
  output logic [NUM_STAGES-1:0] STAGE_OH_o,
  output logic                  ADVANCE_o,
  output logic                  INSTR_DONE_o,
  output logic [1:0]            STATE_o,
  output logic                  TIMEOUT_o,
  output logic [CNT_W-1:0]      CYCLE_COUNT_o,
  output logic [CNT_W-1:0]      INSTR_COUNT_o
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  if ((NUM_STAGES < 2) || (NUM_STAGES > 16)) begin : g_bad_num_stages
    $error("lc3_stage_sequencer: NUM_STAGES must be in 2..16");
  end
  if ((1 << STAGE_W) < NUM_STAGES) begin : g_bad_stage_w
    $error("lc3_stage_sequencer: NUM_STAGES does not fit in STAGE_W");
  end
  if ((MEM_STAGE_MASK >> NUM_STAGES) != 16'd0) begin : g_bad_mask
    $error("lc3_stage_sequencer: MEM_STAGE_MASK has bits beyond NUM_STAGES");
  end
  if ((MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_bad_max_wait
    $error("lc3_stage_sequencer: MAX_WAIT must be in 1..255");
  end

  logic [1:0]            state_q, state_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_W-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0]      ins_cnt_q, ins_cnt_d;

  logic                  start_c;
  logic                  active_c;
  logic                  is_mem_c;
  logic [NUM_STAGES-1:0] stage_oh_c;
  logic                  mem_req_c, advance_c, done_c;
  logic                  wt_start_c, wt_clear_c, wt_en_c, wt_expired;

  assign start_c  = RUN_i && (!STEP_MODE_i || STEP_REQ_i);
  assign active_c = (state_q == ST_ACTIVE) || (state_q == ST_WAIT);

  // Stage decode without indexing the mask by a possibly wider STAGE value
  always_comb begin
    is_mem_c   = 1'b0;
    stage_oh_c = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == STAGE_W'(i)) begin
        is_mem_c      = MEM_STAGE_MASK[i];
        stage_oh_c[i] = active_c;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    timeout_d  = timeout_q;
    cyc_cnt_d  = cyc_cnt_q;
    ins_cnt_d  = ins_cnt_q;
    mem_req_c  = 1'b0;
    advance_c  = 1'b0;
    done_c     = 1'b0;
    wt_start_c = 1'b0;
    wt_clear_c = 1'b0;
    wt_en_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_ACTIVE;
          stage_d = '0;
        end
      end
      ST_ACTIVE, ST_WAIT: begin
        cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        mem_req_c = is_mem_c;
        advance_c = !is_mem_c || MEM_READY_i;
        if (advance_c) begin
          wt_clear_c = 1'b1;
          state_d    = ST_ACTIVE;
          stage_d    = stage_q + STAGE_W'(1);
          if (stage_q == LAST_STAGE) begin
            done_c    = 1'b1;
            ins_cnt_d = ins_cnt_q + CNT_W'(1);
            if (HALT_REQ_i) begin
              state_d = ST_HALTED;
              stage_d = LAST_STAGE;
            end else if (STEP_MODE_i || !RUN_i) begin
              state_d = ST_IDLE;
              stage_d = LAST_STAGE;
            end else begin
              stage_d = '0;
            end
          end
        end else if (state_q == ST_ACTIVE) begin
          state_d    = ST_WAIT;
          wt_start_c = 1'b1;
        end else if (wt_expired) begin
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end else begin
          wt_en_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      stage_q   <= LAST_STAGE;
      timeout_q <= 1'b0;
      cyc_cnt_q <= '0;
      ins_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      timeout_q <= timeout_d;
      cyc_cnt_q <= cyc_cnt_d;
      ins_cnt_q <= ins_cnt_d;
    end
  end

  lc3_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .CLK       (CLK),
    .RESET     (RESET),
    .start_i   (wt_start_c),
    .clear_i   (wt_clear_c),
    .enable_i  (wt_en_c),
    .expired_o (wt_expired)
  );

  assign MEM_REQ_o     = mem_req_c;
  assign ADVANCE_o     = advance_c;
  assign INSTR_DONE_o  = done_c;
  assign STAGE_o       = stage_q;
  assign STAGE_OH_o    = stage_oh_c;
  assign STATE_o       = state_q;
  assign TIMEOUT_o     = timeout_q;
  assign CYCLE_COUNT_o = cyc_cnt_q;
  assign INSTR_COUNT_o = ins_cnt_q;

endmodule
